e_mdu: RTL
==========

# e_mdu

Parametrised multi-cycle multiply/divide unit for the E stage, working alongside the combinational ALU. It executes signed and unsigned multiply and divide over a configurable operand width and holds results in architectural HI/LO registers. While an operation is in flight it raises `busy`, and the hazard unit stalls any following MDU instruction until `busy` clears. It also services mfhi/mflo reads and mthi/mtlo writes.

## Interface
Parameters:
- `WIDTH`, 32: operand width and HI/LO width.
- `MUL_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse launching the op on `opMDU`.
- `opMDU`  in  4  operation code from the shared package.
- `req`  in  1  exception/interrupt request; suppresses `start`, mthi and mtlo in the same cycle.
- `SrcA`  in  WIDTH  rs operand.
- `SrcB`  in  WIDTH  rt operand.
- `busy`  out  1  operation in flight.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.
- `MDUresult`  out  WIDTH  HI for mfhi, LO for mflo, otherwise 0.

## Operation
- Ops: `MDU_mult`, `MDU_multu`, `MDU_div`, `MDU_divu`, `MDU_mthi`, `MDU_mtlo`, `MDU_mfhi`, `MDU_mflo`, `MDU_none`.
- mult/multu: compute the 2·WIDTH-bit product, signed or unsigned. The upper half goes to HI and the lower half to LO.
- div/divu: LO receives the quotient truncated toward zero and HI receives the remainder, which takes the sign of the dividend.
- Divide by zero: HI and LO stay unchanged, but `busy` still runs the full DIV_CYCLES.
- Signed overflow (−2^(WIDTH−1) / −1): LO = −2^(WIDTH−1), HI = 0.
- FSM states:
  - IDLE: a valid start of mult/multu/div/divu loads the result into shadow registers, loads the counter with MUL_CYCLES or DIV_CYCLES, and moves to RUN.
  - RUN: the counter decrements each cycle. At count 1, HI/LO take the shadow values and the FSM returns to IDLE.
- A start is valid only when `start && !req && !busy`. A start while busy is ignored, because the hazard unit guarantees it never occurs.
- mthi/mtlo: write SrcA to HI or LO at the edge when `start && !req && !busy`. They need no busy cycles.
- `req` does not abort an operation already in RUN. It completes and commits.
- mfhi/mflo: combinational reads of the current HI/LO.

## Timing
- Reset: `busy`=0, HI=0, LO=0, FSM=IDLE, counter=0, `MDUresult`=0.
- Start sampled at edge T: `busy`=1 for exactly N cycles after T, where N=MUL_CYCLES or DIV_CYCLES.
- HI/LO change at the edge that drops `busy`, so new values are visible the first cycle `busy`=0.
- The cycle after `busy` falls, a new start is accepted, giving back-to-back throughput of N+1 cycles.
- mthi/mtlo commit at edge T and are readable in cycle T+1.
- Reset asserted mid-RUN: immediate return to reset values and the pending result is discarded.

## Configuration
- `MDU_MADD_EN` defined: adds `MDU_madd`, `MDU_maddu`, `MDU_msub`, `MDU_msubu`.
  - These accumulate {HI,LO} ± product modulo 2^(2·WIDTH) and use MUL_CYCLES.
  - The accumulation uses the {HI,LO} value present at the start edge.
- Undefined: those codes behave as `MDU_none`, with no busy and no HI/LO change.

## Structure
- Shared package (Define.v): `MDU_*` opcodes (4-bit), plus `MDU_MADD_EN` in the global define block.
- Sub-module `e_mdu_core`: combinational signed/unsigned product, quotient, remainder and madd accumulation for width WIDTH.
- `e_mdu` itself holds the FSM, counter, shadow registers and HI/LO.

## Test plan
- Reset: hold `rst_n`=0 → `busy`=0, HI=LO=0. Then mthi 0x12345678 → HI=0x12345678 at T+1.
- mult, SrcA=0xFFFFFFFE (−2), SrcB=3 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div, SrcA=−7, SrcB=2 → `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero after mtlo 5: div 9/0 → `busy` 10 cycles, LO stays 5.
- Start with `req`=1 → `busy` stays 0 and HI/LO are unchanged. A `rst_n` pulse mid-RUN → `busy`=0 immediately and HI=LO=0.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables madd/maddu/msub/msubu).
package e_mdu_pkg;

  localparam logic [3:0] MDU_none  = 4'd0;
  localparam logic [3:0] MDU_mult  = 4'd1;
  localparam logic [3:0] MDU_multu = 4'd2;
  localparam logic [3:0] MDU_div   = 4'd3;
  localparam logic [3:0] MDU_divu  = 4'd4;
  localparam logic [3:0] MDU_mthi  = 4'd5;
  localparam logic [3:0] MDU_mtlo  = 4'd6;
  localparam logic [3:0] MDU_mfhi  = 4'd7;
  localparam logic [3:0] MDU_mflo  = 4'd8;
  localparam logic [3:0] MDU_madd  = 4'd9;
  localparam logic [3:0] MDU_maddu = 4'd10;
  localparam logic [3:0] MDU_msub  = 4'd11;
  localparam logic [3:0] MDU_msubu = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MUL_CYCLES.
  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == MDU_mult) || (op == MDU_multu);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_madd) || (op == MDU_maddu) ||
             (op == MDU_msub) || (op == MDU_msubu);
`endif
    return r;
  endfunction

  // Ops that occupy the unit for DIV_CYCLES.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_div) || (op == MDU_divu);
  endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Combinational datapath of the MDU: product, quotient/remainder and,
// with MDU_MADD_EN defined, {HI,LO} accumulate/subtract.
// Returns the next {HI,LO}; ops that must not modify them pass hi/lo through.
module e_mdu_core
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] prod_s_s;
  logic [2*WIDTH-1:0] prod_u_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic               b_zero_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   b_safe_s;
  logic [WIDTH-1:0]   b_mag_safe_s;
  logic [WIDTH-1:0]   q_mag_s;
  logic [WIDTH-1:0]   r_mag_s;
  logic [WIDTH-1:0]   q_sgn_s;
  logic [WIDTH-1:0]   r_sgn_s;
  logic [WIDTH-1:0]   q_uns_s;
  logic [WIDTH-1:0]   r_uns_s;

  // Sign-extended operands multiplied modulo 2^(2W) give the signed product.
  assign prod_s_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed divide through magnitudes: the most-negative / -1 case falls out
  // naturally as quotient -2^(W-1), remainder 0.
  assign a_neg_s      = a[WIDTH-1];
  assign b_neg_s      = b[WIDTH-1];
  assign b_zero_s     = (b == WIDTH'(0));
  assign a_mag_s      = a_neg_s ? (WIDTH'(0) - a) : a;
  assign b_mag_s      = b_neg_s ? (WIDTH'(0) - b) : b;
  assign b_safe_s     = b_zero_s ? WIDTH'(1) : b;
  assign b_mag_safe_s = b_zero_s ? WIDTH'(1) : b_mag_s;
  assign q_mag_s      = a_mag_s / b_mag_safe_s;
  assign r_mag_s      = a_mag_s % b_mag_safe_s;
  assign q_sgn_s      = (a_neg_s ^ b_neg_s) ? (WIDTH'(0) - q_mag_s) : q_mag_s;
  assign r_sgn_s      = a_neg_s ? (WIDTH'(0) - r_mag_s) : r_mag_s;
  assign q_uns_s      = a / b_safe_s;
  assign r_uns_s      = a % b_safe_s;

  // Select the next {HI,LO} for the requested op.
  always_comb begin
    hi_res = hi;
    lo_res = lo;
    case (op)
      MDU_mult:  {hi_res, lo_res} = prod_s_s;
      MDU_multu: {hi_res, lo_res} = prod_u_s;
      MDU_div: begin
        if (b_zero_s) begin
          hi_res = hi;
          lo_res = lo;
        end else begin
          hi_res = r_sgn_s;
          lo_res = q_sgn_s;
        end
      end
      MDU_divu: begin
        if (b_zero_s) begin
          hi_res = hi;
          lo_res = lo;
        end else begin
          hi_res = r_uns_s;
          lo_res = q_uns_s;
        end
      end
`ifdef MDU_MADD_EN
      MDU_madd:  {hi_res, lo_res} = {hi, lo} + prod_s_s;
      MDU_maddu: {hi_res, lo_res} = {hi, lo} + prod_u_s;
      MDU_msub:  {hi_res, lo_res} = {hi, lo} - prod_s_s;
      MDU_msubu: {hi_res, lo_res} = {hi, lo} - prod_u_s;
`endif
      default: begin
        hi_res = hi;
        lo_res = lo;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit with architectural HI/LO.
// Results are computed at the start edge into shadow registers and
// committed to HI/LO at the edge that drops busy.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu).
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opMDU,
  input  logic             req,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDUresult
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_sh_r;
  logic [WIDTH-1:0] lo_sh_r;
  logic [WIDTH-1:0] hi_res_s;
  logic [WIDTH-1:0] lo_res_s;
  logic             go_s;
  logic             mul_op_s;
  logic             long_op_s;

  e_mdu_core #(.WIDTH(WIDTH)) u_core (
    .op     (opMDU),
    .a      (SrcA),
    .b      (SrcB),
    .hi     (hi_r),
    .lo     (lo_r),
    .hi_res (hi_res_s),
    .lo_res (lo_res_s)
  );

  assign go_s      = start && !req && !busy_r;
  assign mul_op_s  = is_mul_op(opMDU);
  assign long_op_s = mul_op_s || is_div_op(opMDU);

  // Sequencer: launch, count down, commit shadows to HI/LO; mthi/mtlo write directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_W'(0);
      busy_r  <= 1'b0;
      hi_r    <= WIDTH'(0);
      lo_r    <= WIDTH'(0);
      hi_sh_r <= WIDTH'(0);
      lo_sh_r <= WIDTH'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s && long_op_s) begin
            hi_sh_r <= hi_res_s;
            lo_sh_r <= lo_res_s;
            cnt_r   <= mul_op_s ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else if (go_s && (opMDU == MDU_mthi)) begin
            hi_r <= SrcA;
          end else if (go_s && (opMDU == MDU_mtlo)) begin
            lo_r <= SrcA;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_W'(1)) begin
            hi_r    <= hi_sh_r;
            lo_r    <= lo_sh_r;
            cnt_r   <= CNT_W'(0);
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          cnt_r   <= CNT_W'(0);
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

  // mfhi/mflo read port straight from the architectural registers.
  always_comb begin
    MDUresult = WIDTH'(0);
    case (opMDU)
      MDU_mfhi: MDUresult = hi_r;
      MDU_mflo: MDUresult = lo_r;
      default:  MDUresult = WIDTH'(0);
    endcase
  end

endmodule
